// File: rtl/fp16_to_fix_pipe.sv
// Three-stage FP16 -> signed fixed-point converter with valid/ready on both sides.
// Stages: unpack/classify, align, sign/saturate; the whole pipe shifts or holds as one.
module fp16_to_fix_pipe #(
    parameter int OUT_W  = 32,
    parameter int FRAC_W = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             arg_0,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] ret_0,
    output logic                    ret_sat,
    output logic                    ret_nan
);

    // Wide enough that no set mantissa bit can fall off the top for any legal shift.
    localparam int WIDE_W = OUT_W + 64;

    // Returns {ovf, mag}. Limit is 2^(OUT_W-1)-1 for positive, 2^(OUT_W-1) for negative.
    function automatic logic [OUT_W:0] align(input logic [10:0] m,
                                             input logic signed [6:0] sh,
                                             input logic s);
        logic [WIDE_W-1:0] w;
        logic [6:0]        nsh;
        logic [OUT_W-1:0]  mag;
        logic              ovf;
        w   = {{(WIDE_W-11){1'b0}}, m};
        nsh = 7'(-sh);
        if (sh[6])
            w = w >> nsh;
        else
            w = w << $unsigned(sh);
        mag = w[OUT_W-1:0];
        ovf = (|w[WIDE_W-1:OUT_W]) || (mag[OUT_W-1] && (!s || (|mag[OUT_W-2:0])));
        return {ovf, mag};
    endfunction

    // Returns {nan, sat, value}.
    function automatic logic [OUT_W+1:0] saturate(input logic s, input logic nan,
                                                  input logic inf, input logic ovf,
                                                  input logic [OUT_W-1:0] mag);
        logic signed [OUT_W-1:0] val;
        if (nan)
            return {1'b1, 1'b0, {OUT_W{1'b0}}};
        if (inf || ovf) begin
            val = s ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            return {1'b0, 1'b1, val};
        end
        val = s ? -$signed(mag) : $signed(mag);
        return {1'b0, 1'b0, val};
    endfunction

    logic                    adv;
    logic [4:0]              exp_in;
    logic [9:0]              frac_in;
    logic                    nan_in, inf_in;
    logic [10:0]             man_in;
    logic signed [6:0]       sh_in;

    logic                    vld_p0, sgn_p0, nan_p0, inf_p0;
    logic [10:0]             man_p0;
    logic signed [6:0]       sh_p0;
    logic [OUT_W:0]          aln_p0;

    logic                    vld_p1, sgn_p1, nan_p1, inf_p1, ovf_p1;
    logic [OUT_W-1:0]        mag_p1;
    logic [OUT_W+1:0]        res_p1;

    logic                    vld_p2;

    assign adv       = !vld_p2 || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p2;

    assign exp_in  = arg_0[14:10];
    assign frac_in = arg_0[9:0];
    assign nan_in  = (exp_in == 5'd31) && (frac_in != 10'd0);
    assign inf_in  = (exp_in == 5'd31) && (frac_in == 10'd0);
    // Zero and denormals carry a zero mantissa, so they align to 0 with no flags.
    assign man_in  = (exp_in == 5'd0) ? 11'd0 : {1'b1, frac_in};
    assign sh_in   = $signed({2'b00, exp_in}) - 7'sd25 + $signed(7'(FRAC_W));

    assign aln_p0  = align(man_p0, sh_p0, sgn_p0);
    assign res_p1  = saturate(sgn_p1, nan_p1, inf_p1, ovf_p1, mag_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // S0: unpack/classify
    always_ff @(posedge clk) begin
        if (adv) begin
            sgn_p0 <= arg_0[15];
            nan_p0 <= nan_in;
            inf_p0 <= inf_in;
            man_p0 <= man_in;
            sh_p0  <= sh_in;
        end
    end

    // S1: align
    always_ff @(posedge clk) begin
        if (adv) begin
            sgn_p1 <= sgn_p0;
            nan_p1 <= nan_p0;
            inf_p1 <= inf_p0;
            ovf_p1 <= aln_p0[OUT_W];
            mag_p1 <= aln_p0[OUT_W-1:0];
        end
    end

    // S2: sign/saturate into the output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_0   <= '0;
            ret_sat <= 1'b0;
            ret_nan <= 1'b0;
        end else if (adv && vld_p1) begin
            ret_nan <= res_p1[OUT_W+1];
            ret_sat <= res_p1[OUT_W];
            ret_0   <= res_p1[OUT_W-1:0];
        end
    end

endmodule
